// File: rtl/lcd_byte_scheduler.sv
// lcd_byte_scheduler: arbitrates two byte requesters onto a 4-bit character-LCD bus,
// sending each byte as upper then lower nibble with timed enable pulses and a post-byte wait.
// Ports: Clock, Reset (sync, active-low); iReqN_Valid/RS/Data in, oReqN_Ready out (port 0 wins);
//        oLCD_Enabled/RegisterSelect/ReadWrite/Data to the LCD pins; oBusy, oGrant status.
// Option: define LCD_CLEAR_WAIT_EN to give clear/home commands (0x01..0x03, RS=0) CLEAR_WAIT.
module lcd_byte_scheduler #(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned PULSE_CYC  = 12,
    parameter int unsigned HOLD_CYC   = 2,
    parameter int unsigned GAP_CYC    = 50,
    parameter int unsigned CMD_WAIT   = 2000,
    parameter int unsigned CLEAR_WAIT = 82000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iReq0_Valid,
    input  logic       iReq0_RS,
    input  logic [7:0] iReq0_Data,
    output logic       oReq0_Ready,
    input  logic       iReq1_Valid,
    input  logic       iReq1_RS,
    input  logic [7:0] iReq1_Data,
    output logic       oReq1_Ready,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic       oLCD_ReadWrite,
    output logic [3:0] oLCD_Data,
    output logic       oBusy,
    output logic       oGrant
);

    typedef enum logic [3:0] {
        IDLE,
        HI_SETUP,
        HI_PULSE,
        HI_HOLD,
        GAP,
        LO_SETUP,
        LO_PULSE,
        LO_HOLD,
        WAIT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        rs_q, rs_d;
    logic [7:0]  data_q, data_d;
    logic        port_q, port_d;

    logic [31:0] dur;
    logic [31:0] wait_len;
    logic        last_cyc;
    logic        accept0;
    logic        accept1;

    // Ready is masked by Reset so nothing is offered while the block is held in reset.
    assign oReq0_Ready = (state_q == IDLE) && Reset;
    assign oReq1_Ready = oReq0_Ready && !iReq0_Valid;
    assign accept0     = iReq0_Valid && oReq0_Ready;
    assign accept1     = iReq1_Valid && oReq1_Ready;

`ifdef LCD_CLEAR_WAIT_EN
    logic is_clear;
    assign is_clear = !rs_q &&
                      ((data_q == 8'h01) || (data_q == 8'h02) || (data_q == 8'h03));
    assign wait_len = is_clear ? 32'(CLEAR_WAIT) : 32'(CMD_WAIT);
`else
    logic [31:0] unused_clear_wait;
    assign unused_clear_wait = 32'(CLEAR_WAIT);
    assign wait_len          = 32'(CMD_WAIT);
`endif

    // Length of the current timed state; IDLE is untimed.
    always_comb begin
        dur = 32'd1;
        unique case (state_q)
            HI_SETUP, LO_SETUP: dur = 32'(SETUP_CYC);
            HI_PULSE, LO_PULSE: dur = 32'(PULSE_CYC);
            HI_HOLD,  LO_HOLD:  dur = 32'(HOLD_CYC);
            GAP:                dur = 32'(GAP_CYC);
            WAIT:               dur = wait_len;
            default:            dur = 32'd1;
        endcase
    end

    assign last_cyc = (cnt_q == (dur - 32'd1));

    // State register
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= 32'd0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            port_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            port_q  <= port_d;
        end
    end

    // Next state, byte capture and cycle counter
    always_comb begin
        state_d = state_q;
        rs_d    = rs_q;
        data_d  = data_q;
        port_d  = port_q;
        unique case (state_q)
            IDLE: begin
                if (accept0) begin
                    state_d = HI_SETUP;
                    rs_d    = iReq0_RS;
                    data_d  = iReq0_Data;
                    port_d  = 1'b0;
                end else if (accept1) begin
                    state_d = HI_SETUP;
                    rs_d    = iReq1_RS;
                    data_d  = iReq1_Data;
                    port_d  = 1'b1;
                end
            end
            HI_SETUP: if (last_cyc) state_d = HI_PULSE;
            HI_PULSE: if (last_cyc) state_d = HI_HOLD;
            HI_HOLD:  if (last_cyc) state_d = GAP;
            GAP:      if (last_cyc) state_d = LO_SETUP;
            LO_SETUP: if (last_cyc) state_d = LO_PULSE;
            LO_PULSE: if (last_cyc) state_d = LO_HOLD;
            LO_HOLD:  if (last_cyc) state_d = WAIT;
            WAIT:     if (last_cyc) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        // Counter restarts from zero on every state change and rests at zero in IDLE.
        if ((state_d != state_q) || (state_q == IDLE)) begin
            cnt_d = 32'd0;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Outputs
    always_comb begin
        oLCD_Enabled        = 1'b0;
        oLCD_RegisterSelect = 1'b0;
        oLCD_ReadWrite      = 1'b0;
        oLCD_Data           = 4'h0;
        oBusy               = (state_q != IDLE);
        oGrant              = 1'b0;
        unique case (state_q)
            HI_SETUP, HI_HOLD: begin
                oLCD_RegisterSelect = rs_q;
                oLCD_Data           = data_q[7:4];
                oGrant              = port_q;
            end
            HI_PULSE: begin
                oLCD_Enabled        = 1'b1;
                oLCD_RegisterSelect = rs_q;
                oLCD_Data           = data_q[7:4];
                oGrant              = port_q;
            end
            GAP: begin
                oLCD_RegisterSelect = rs_q;
                oGrant              = port_q;
            end
            LO_SETUP, LO_HOLD: begin
                oLCD_RegisterSelect = rs_q;
                oLCD_Data           = data_q[3:0];
                oGrant              = port_q;
            end
            LO_PULSE: begin
                oLCD_Enabled        = 1'b1;
                oLCD_RegisterSelect = rs_q;
                oLCD_Data           = data_q[3:0];
                oGrant              = port_q;
            end
            WAIT: begin
                oGrant = port_q;
            end
            default: begin
                oGrant = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_byte_scheduler.sv
// tb_lcd_byte_scheduler: directed bench for lcd_byte_scheduler with a
// phase-offset reference model checked every cycle plus literal timing checks.
module tb_lcd_byte_scheduler;

    localparam int S   = 2;
    localparam int P   = 12;
    localparam int H   = 2;
    localparam int G   = 50;
    localparam int CW  = 2000;
    localparam int CLR = 5000;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       iReq0_Valid = 1'b0;
    logic       iReq0_RS = 1'b0;
    logic [7:0] iReq0_Data = 8'h00;
    logic       iReq1_Valid = 1'b0;
    logic       iReq1_RS = 1'b0;
    logic [7:0] iReq1_Data = 8'h00;
    logic       oReq0_Ready;
    logic       oReq1_Ready;
    logic       oLCD_Enabled;
    logic       oLCD_RegisterSelect;
    logic       oLCD_ReadWrite;
    logic [3:0] oLCD_Data;
    logic       oBusy;
    logic       oGrant;

    lcd_byte_scheduler #(
        .SETUP_CYC (S),
        .PULSE_CYC (P),
        .HOLD_CYC  (H),
        .GAP_CYC   (G),
        .CMD_WAIT  (CW),
        .CLEAR_WAIT(CLR)
    ) dut (
        .Clock              (Clock),
        .Reset              (Reset),
        .iReq0_Valid        (iReq0_Valid),
        .iReq0_RS           (iReq0_RS),
        .iReq0_Data         (iReq0_Data),
        .oReq0_Ready        (oReq0_Ready),
        .iReq1_Valid        (iReq1_Valid),
        .iReq1_RS           (iReq1_RS),
        .iReq1_Data         (iReq1_Data),
        .oReq1_Ready        (oReq1_Ready),
        .oLCD_Enabled       (oLCD_Enabled),
        .oLCD_RegisterSelect(oLCD_RegisterSelect),
        .oLCD_ReadWrite     (oLCD_ReadWrite),
        .oLCD_Data          (oLCD_Data),
        .oBusy              (oBusy),
        .oGrant             (oGrant)
    );

    always #5 Clock = ~Clock;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    // Reference model: one byte in flight, described by accept edge and byte.
    bit       m_busy = 1'b0;
    int       m_T    = 0;
    bit       m_rs   = 1'b0;
    bit [7:0] m_d    = 8'h00;
    bit       m_port = 1'b0;
    int       m_wait = CW;

    function automatic int wait_for(bit rs, bit [7:0] d);
`ifdef LCD_CLEAR_WAIT_EN
        if (!rs && d >= 8'h01 && d <= 8'h03) return CLR;
`endif
        return CW;
    endfunction

    function automatic int total_len(int w);
        return S + P + H + G + S + P + H + w;
    endfunction

    // True when the cycle ending at edge e carries no byte.
    function automatic bit m_idle(int e);
        int k;
        k = e - m_T;
        return !(m_busy && k >= 1 && k <= total_len(m_wait));
    endfunction

    always @(posedge Clock) begin
        cyc++;
        if (!Reset) begin
            m_busy  = 1'b0;
            started = 1'b1;
        end else if (m_idle(cyc)) begin
            if (iReq0_Valid) begin
                m_busy = 1'b1; m_T = cyc; m_port = 1'b0;
                m_rs = iReq0_RS; m_d = iReq0_Data;
                m_wait = wait_for(iReq0_RS, iReq0_Data);
            end else if (iReq1_Valid) begin
                m_busy = 1'b1; m_T = cyc; m_port = 1'b1;
                m_rs = iReq1_RS; m_d = iReq1_Data;
                m_wait = wait_for(iReq1_RS, iReq1_Data);
            end else begin
                m_busy = 1'b0;
            end
        end
    end

    // {r0, r1, E, RS, RW, D[3:0], busy, grant}
    function automatic logic [10:0] model_vec();
        int k, b1, b2, b3, b4, b5, b6, b7;
        bit busy, r0, r1, e, rs;
        bit [3:0] d;
        k  = cyc - m_T + 1;
        b1 = S; b2 = b1 + P; b3 = b2 + H; b4 = b3 + G;
        b5 = b4 + S; b6 = b5 + P; b7 = b6 + H;
        busy = m_busy && k >= 1 && k <= total_len(m_wait);
        r0 = !busy && Reset;
        r1 = r0 && !iReq0_Valid;
        e  = 1'b0; rs = 1'b0; d = 4'h0;
        if (busy) begin
            e  = (k > b1 && k <= b2) || (k > b5 && k <= b6);
            rs = (k <= b7) ? m_rs : 1'b0;
            if (k <= b3) d = m_d[7:4];
            else if (k > b4 && k <= b7) d = m_d[3:0];
        end
        return {r0, r1, e, rs, 1'b0, d, busy, busy ? m_port : 1'b0};
    endfunction

    always @(negedge Clock) begin
        logic [10:0] exp_v, act_v;
        if (started) begin
            exp_v = model_vec();
            act_v = {oReq0_Ready, oReq1_Ready, oLCD_Enabled, oLCD_RegisterSelect,
                     oLCD_ReadWrite, oLCD_Data, oBusy, oGrant};
            n_chk++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL model cyc=%0d got=%b exp=%b", cyc, act_v, exp_v);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp_v);
        end
    endtask

    // Offer one byte; T returns the accept edge.
    task automatic send(input bit port, input bit rs, input logic [7:0] d,
                        input bit hold, output int T);
        @(posedge Clock); #1;
        if (port) begin
            iReq1_Valid = 1'b1; iReq1_RS = rs; iReq1_Data = d;
        end else begin
            iReq0_Valid = 1'b1; iReq0_RS = rs; iReq0_Data = d;
        end
        T = -1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge Clock);
            if (port ? oReq1_Ready : oReq0_Ready) begin
                T = cyc + 1;
                break;
            end
        end
        if (T < 0) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout port=%0d got=0 exp=1", port);
            T = cyc;
        end
        @(posedge Clock); #1;
        if (!hold) begin
            if (port) iReq1_Valid = 1'b0;
            else iReq0_Valid = 1'b0;
        end
    endtask

    // Advance to the negedge of offset k (k=1 is the first cycle after accept).
    task automatic at_k(input int T, input int k);
        do @(negedge Clock); while ((cyc - T + 1) < k);
    endtask

    typedef struct { int k; int e; int rs; int d; } vec_t;
    vec_t tb41[14] = '{
        '{1, 0, 1, 4}, '{2, 0, 1, 4}, '{3, 1, 1, 4}, '{14, 1, 1, 4},
        '{15, 0, 1, 4}, '{16, 0, 1, 4}, '{17, 0, 1, 0}, '{66, 0, 1, 0},
        '{67, 0, 1, 1}, '{69, 1, 1, 1}, '{80, 1, 1, 1}, '{81, 0, 1, 1},
        '{82, 0, 1, 1}, '{83, 0, 0, 0}
    };

    initial begin
        int T, T0, T1, cnt_e, cnt_d, end_k, n_acc, erise;
        int acc[3];
        bit pe;

        repeat (3) @(posedge Clock);
        #1 Reset = 1'b1;
        @(negedge Clock);
        chk("rst_busy", oBusy, 0);
        chk("rst_ready0", oReq0_Ready, 1);
        chk("rst_ready1", oReq1_Ready, 1);
        chk("rst_e", oLCD_Enabled, 0);
        chk("rst_rw", oLCD_ReadWrite, 0);
        chk("rst_grant", oGrant, 0);

        // Reset in the middle of the upper-nibble pulse
        send(1'b0, 1'b0, 8'hA5, 1'b0, T);
        at_k(T, 5);
        chk("mid_e_before", oLCD_Enabled, 1);
        @(posedge Clock); #1 Reset = 1'b0;
        @(negedge Clock);
        chk("mid_ready_in_rst", oReq0_Ready, 0);
        @(posedge Clock); #1;
        chk("mid_e_after", oLCD_Enabled, 0);
        chk("mid_rs_after", oLCD_RegisterSelect, 0);
        chk("mid_d_after", oLCD_Data, 0);
        chk("mid_busy_after", oBusy, 0);
        repeat (3) @(posedge Clock);
        #1 Reset = 1'b1;
        cnt_e = 0; cnt_d = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge Clock);
            if (oLCD_Enabled) cnt_e++;
            if (oLCD_Data != 4'h0) cnt_d++;
        end
        chk("mid_no_e", cnt_e, 0);
        chk("mid_no_data", cnt_d, 0);

        // Port 1 data byte 0x41
        send(1'b1, 1'b1, 8'h41, 1'b0, T);
        foreach (tb41[i]) begin
            at_k(T, tb41[i].k);
            chk($sformatf("b41_e_k%0d", tb41[i].k), oLCD_Enabled, tb41[i].e);
            chk($sformatf("b41_rs_k%0d", tb41[i].k), oLCD_RegisterSelect, tb41[i].rs);
            chk($sformatf("b41_d_k%0d", tb41[i].k), oLCD_Data, tb41[i].d);
        end
        at_k(T, 2082);
        chk("b41_busy_2082", oBusy, 1);
        at_k(T, 2083);
        chk("b41_busy_2083", oBusy, 0);
        chk("b41_ready1_2083", oReq1_Ready, 1);

        // Both ports at once: port 0 first, port 1 next
        @(posedge Clock); #1;
        iReq0_Valid = 1'b1; iReq0_RS = 1'b0; iReq0_Data = 8'h28;
        iReq1_Valid = 1'b1; iReq1_RS = 1'b1; iReq1_Data = 8'h48;
        @(negedge Clock);
        chk("both_r0", oReq0_Ready, 1);
        chk("both_r1", oReq1_Ready, 0);
        T0 = cyc + 1;
        @(posedge Clock); #1 iReq0_Valid = 1'b0;
        @(negedge Clock);
        chk("both_grant0", oGrant, 0);
        chk("both_d_hi28", oLCD_Data, 2);
        T1 = -1;
        for (int i = 0; i < 2200; i++) begin
            @(negedge Clock);
            if (oReq1_Ready) begin T1 = cyc + 1; break; end
        end
        chk("both_t1_gap", T1 - T0, 2083);
        @(posedge Clock); #1 iReq1_Valid = 1'b0;
        @(negedge Clock);
        chk("both_grant1", oGrant, 1);
        chk("both_d_hi48", oLCD_Data, 4);
        at_k(T1, 2083);
        chk("both_idle", oBusy, 0);

        // Clear-display command on port 0
`ifdef LCD_CLEAR_WAIT_EN
        end_k = 83 + CLR;
`else
        end_k = 2083;
`endif
        send(1'b0, 1'b0, 8'h01, 1'b0, T);
        at_k(T, end_k - 1);
        chk("clr_busy_last", oBusy, 1);
        at_k(T, end_k);
        chk("clr_idle", oBusy, 0);

        // Same byte as data always uses the normal wait
        send(1'b0, 1'b1, 8'h01, 1'b0, T);
        at_k(T, 2082);
        chk("dat01_busy_last", oBusy, 1);
        at_k(T, 2083);
        chk("dat01_idle", oBusy, 0);

        // Three back-to-back bytes with Valid held
        @(posedge Clock); #1;
        iReq1_Valid = 1'b1; iReq1_RS = 1'b1; iReq1_Data = 8'h33;
        n_acc = 0; erise = 0; pe = 1'b0;
        for (int i = 0; i < 7000 && n_acc < 3; i++) begin
            @(negedge Clock);
            if (oLCD_Enabled && !pe) erise++;
            pe = oLCD_Enabled;
            if (oReq1_Ready) begin acc[n_acc] = cyc + 1; n_acc++; end
        end
        @(posedge Clock); #1 iReq1_Valid = 1'b0;
        for (int i = 0; i < 2100; i++) begin
            @(negedge Clock);
            if (oLCD_Enabled && !pe) erise++;
            pe = oLCD_Enabled;
        end
        chk("b2b_accepts", n_acc, 3);
        if (n_acc == 3) begin
            chk("b2b_gap1", acc[1] - acc[0], 2083);
            chk("b2b_gap2", acc[2] - acc[1], 2083);
        end
        chk("b2b_e_count", erise, 6);
        chk("b2b_idle", oBusy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
